memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 22 ++
 rtl/memory_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and the data memory (slave).
// Handshake: the master raises dmem_req with dmem_we/addr/be/wdata and holds them stable until
// the slave pulses dmem_ack for exactly one cycle. The slave drives dmem_rdata in that cycle.
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues loads/stores on the dmem bus, stalls upstream until ack, feeds MEM/WB.
// Define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of truncating them.
module memory_stage (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dest_addr,
    input  logic             write_or_not,
    input  logic [31:0]      wdata,
    input  logic [3:0]       mem_op,
    input  logic [31:0]      store_data,
    memory_stage_if.master   dmem,
    output logic             stall_req,
    output logic [4:0]       dest_addr_output,
    output logic             write_or_not_output,
    output logic [31:0]      wdata_output,
    output logic             align_exc,
    output logic             state_dbg
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, mwdata_q, mwdata_d;
    logic [3:0]  be_q, be_d, op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  dest_q, dest_d, dout_q, dout_d;
    logic        wen_q, wen_d, wout_q, wout_d, exc_q, exc_d;
    logic [31:0] alu_q, alu_d, rout_q, rout_d;

    logic        is_load, is_store, is_half, is_word, mem_valid, align_hit;
    logic [1:0]  lo_t;
    logic [3:0]  be_t;
    logic [31:0] wd_t, load_val;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
        is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
        is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
        align_hit = (is_half && wdata[0]) || (is_word && (wdata[1:0] != 2'b00));
        mem_valid = (is_load || is_store) && !align_hit;
`else
        align_hit = 1'b0;
        mem_valid = is_load || is_store;
`endif
        // Without the check, sub-word offsets are truncated to the access-size boundary.
        lo_t = is_word ? 2'b00 : (is_half ? {wdata[1], 1'b0} : wdata[1:0]);
        be_t = 4'b1111;
        wd_t = 32'h0;
        case (mem_op)
            OP_SB:   begin be_t = 4'b0001 << lo_t; wd_t = {4{store_data[7:0]}}; end
            OP_SH:   begin be_t = lo_t[1] ? 4'b1100 : 4'b0011; wd_t = {2{store_data[15:0]}}; end
            OP_SW:   wd_t = store_data;
            default: ;
        endcase
    end

    always_comb begin
        case (lo_q)
            2'd0:    rbyte = dmem.dmem_rdata[7:0];
            2'd1:    rbyte = dmem.dmem_rdata[15:8];
            2'd2:    rbyte = dmem.dmem_rdata[23:16];
            default: rbyte = dmem.dmem_rdata[31:24];
        endcase
        rhalf = lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_val = {24'h0, rbyte};
            OP_LH:   load_val = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_val = {16'h0, rhalf};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d = req_q; we_d = we_q; addr_d = addr_q; be_d = be_q; mwdata_d = mwdata_q;
        op_d = op_q; lo_d = lo_q; dest_d = dest_q; wen_d = wen_q; alu_d = alu_q;
        dout_d = 5'd0; wout_d = 1'b0; rout_d = 32'h0; exc_d = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                stall_req = mem_valid;
                if (mem_valid) begin
                    state_d = BUSY;
                    req_d = 1'b1; we_d = is_store; addr_d = {wdata[31:2], 2'b00};
                    be_d = be_t; mwdata_d = wd_t;
                    op_d = mem_op; lo_d = lo_t; dest_d = dest_addr; wen_d = write_or_not; alu_d = wdata;
                end else if (align_hit) begin
                    exc_d = 1'b1; dout_d = dest_addr; rout_d = wdata;
                end else begin
                    dout_d = dest_addr; wout_d = write_or_not; rout_d = wdata;
                end
            end
            default: begin
                stall_req = !dmem.dmem_ack;
                if (dmem.dmem_ack) begin
                    state_d = IDLE;
                    req_d = 1'b0; we_d = 1'b0; addr_d = 32'h0; be_d = 4'h0; mwdata_d = 32'h0;
                    dout_d = dest_q;
                    wout_d = (op_q <= OP_LW) ? wen_q : 1'b0;
                    rout_d = (op_q <= OP_LW) ? load_val : alu_q;
                end
            end
        endcase
        // Reset wins over any in-flight access, including an ack in the same cycle.
        if (rst) begin
            state_d = IDLE;
            req_d = 1'b0; we_d = 1'b0; addr_d = 32'h0; be_d = 4'h0; mwdata_d = 32'h0;
            op_d = 4'h0; lo_d = 2'b00; dest_d = 5'd0; wen_d = 1'b0; alu_d = 32'h0;
            dout_d = 5'd0; wout_d = 1'b0; rout_d = 32'h0; exc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        req_q <= req_d; we_q <= we_d; addr_q <= addr_d; be_q <= be_d; mwdata_q <= mwdata_d;
        op_q <= op_d; lo_q <= lo_d; dest_q <= dest_d; wen_q <= wen_d; alu_q <= alu_d;
        dout_q <= dout_d; wout_q <= wout_d; rout_q <= rout_d; exc_q <= exc_d;
    end

    assign dmem.dmem_req        = req_q;
    assign dmem.dmem_we         = we_q;
    assign dmem.dmem_addr       = addr_q;
    assign dmem.dmem_be         = be_q;
    assign dmem.dmem_wdata      = mwdata_q;
    assign dest_addr_output     = dout_q;
    assign write_or_not_output  = wout_q;
    assign wdata_output         = rout_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign align_exc            = exc_q;
`else
    assign align_exc            = 1'b0;
`endif
    assign state_dbg            = (state_q == BUSY);
endmodule
